alu_seq_ctrl: RTL and testbench

Command-driven sequencer that runs one ALU operation per command against the register file. It accepts an `{op, rs, rt, rd}` command over a valid/ready handshake and reads both source registers. It drives the `alu` datapath, writes the result to `rd`, and returns result, flags and status over a second valid/ready handshake. It sits between the instruction/test front end and the existing regfile + `alu` pair and is the only writer of the regfile write port.

---
 rtl/alu_defs.sv | 25 ++
 rtl/alu.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared opcode constants and controller state encoding.
// Pure definitions: no logic, no latency.
// Backpressure: not applicable.
package alu_defs;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] A_NOP  = 5'd0;
    localparam logic [OP_W-1:0] A_ADD  = 5'd1;
    localparam logic [OP_W-1:0] A_SUB  = 5'd2;
    localparam logic [OP_W-1:0] A_AND  = 5'd3;
    localparam logic [OP_W-1:0] A_OR   = 5'd4;
    localparam logic [OP_W-1:0] A_XOR  = 5'd5;
    localparam logic [OP_W-1:0] A_NOR  = 5'd6;
    localparam logic [OP_W-1:0] OP_MAX = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result = op(a, b); unknown opcodes and NOP yield 0.
// Latency: zero cycles (purely combinational).
// Backpressure: none; ports i_op/i_a/i_b in, o_result out.
module alu
    import alu_defs::*;
#(
    parameter int DW = 32
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [DW-1:0]   o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            A_ADD:   o_result = i_a + i_b;
            A_SUB:   o_result = i_a - i_b;
            A_AND:   o_result = i_a & i_b;
            A_OR:    o_result = i_a | i_b;
            A_XOR:   o_result = i_a ^ i_b;
            A_NOR:   o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer: read rs/rt, run the alu, write rd, return result+flags.
// Latency: response 4 cycles after accept (3 for NOP/illegal), one command in flight.
// Backpressure: rsp_* held until rsp_ready; cmd_ready low until the response is taken.
// Ports: cmd_* command in, rf_* regfile read/write, rsp_* response out, op_count.
module alu_seq_ctrl
    import alu_defs::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [AW-1:0]   cmd_rs,
    input  logic [AW-1:0]   cmd_rt,
    input  logic [AW-1:0]   cmd_rd,
    output logic [AW-1:0]   rf_raddr1,
    output logic [AW-1:0]   rf_raddr2,
    input  logic [DW-1:0]   rf_rdata1,
    input  logic [DW-1:0]   rf_rdata2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_zero,
    output logic            rsp_ovf,
    output logic            rsp_err,
    output logic [CW-1:0]   op_count
);

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    logic [AW-1:0]   r_rs, r_rt, r_rd;
    logic [DW-1:0]   r_op_a, r_op_b;
    logic            r_we;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_zero, r_ovf, r_err;
    logic [CW-1:0]   r_count;

    logic [DW-1:0]   w_alu_res;
    logic            w_ovf;

    alu #(.DW(DW)) u_alu (
        .i_op     (r_op),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_alu_res)
    );

    // Signed overflow from operand/result sign bits; only ADD/SUB can overflow.
    always_comb begin
        w_ovf = 1'b0;
        case (r_op)
            A_ADD: w_ovf = (r_op_a[DW-1] == r_op_b[DW-1]) && (w_alu_res[DW-1] != r_op_a[DW-1]);
            A_SUB: w_ovf = (r_op_a[DW-1] != r_op_b[DW-1]) && (w_alu_res[DW-1] != r_op_a[DW-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rs    <= cmd_rs;
                        r_rt    <= cmd_rt;
                        r_rd    <= cmd_rd;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // Sources are captured here, before WB, so rd==rs/rt sees the old value.
                    r_op_a  <= rf_rdata1;
                    r_op_b  <= rf_rdata2;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_op > OP_MAX) begin
                        r_rsp_data  <= '0;
                        r_zero      <= 1'b1;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_rsp_data <= w_alu_res;
                        r_zero     <= (w_alu_res == '0);
                        r_ovf      <= w_ovf;
                        r_err      <= 1'b0;
                        if (r_op == A_NOP) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_we    <= 1'b1;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_count     <= r_count + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && rst_n;
    assign rf_raddr1 = r_rs;
    assign rf_raddr2 = r_rt;
    assign rf_we     = r_we;
    // Write data/address come straight from the registered result and latched rd.
    assign rf_waddr  = r_rd;
    assign rf_wdata  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_zero;
    assign rsp_ovf   = r_ovf;
    assign rsp_err   = r_err;
    assign op_count  = r_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_ovf, rsp_err;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    // Regfile owned by the bench; tb_we lets the bench preload it while the DUT is idle.
    logic [31:0] rf [32];
    logic [31:0] mdl [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    alu_seq_ctrl #(.DW(32), .AW(5), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow from the true mathematical result leaving the 32-bit range.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic v,
                                  output logic e, output logic wr);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint s  = 0;
        r = '0; v = 1'b0; e = 1'b0; wr = 1'b1;
        case (op)
            5'd0: wr = 1'b0;
            5'd1: begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd2: begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            5'd6: r = ~(a | b);
            default: begin e = 1'b1; wr = 1'b0; end
        endcase
        z = (r == 32'd0);
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = v;
        @(negedge clk);
        tb_we = 1'b0;
        mdl[a] = v;
    endtask

    // Issue one command, check timing/writeback/response; bp holds rsp_ready low for 10 cycles.
    task automatic do_cmd(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input bit bp);
        logic [31:0] er, we_data;
        logic        ez, ev, ee, ew;
        logic [4:0]  we_addr;
        int          we_cnt, we_cyc, rsp_cyc, w;
        we_cnt = 0; we_cyc = 0; rsp_cyc = 0; w = 0; we_addr = '0; we_data = '0;
        model(op, mdl[rs], mdl[rt], er, ez, ev, ee, ew);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        if (bp) rsp_ready = 1'b0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rf_we) begin we_cnt++; we_cyc = k; we_addr = rf_waddr; we_data = rf_wdata; end
            if (rsp_valid) begin rsp_cyc = k; break; end
        end
        chk("rsp_cycle", rsp_cyc, ew ? 32'd4 : 32'd3);
        chk("we_count", we_cnt, ew ? 32'd1 : 32'd0);
        if (ew) begin
            chk("we_cycle", we_cyc, 32'd3);
            chk("we_addr", {27'd0, we_addr}, {27'd0, rd});
            chk("we_data", we_data, er);
        end
        chk("rsp_data", rsp_data, er);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, ez});
        chk("rsp_ovf",  {31'd0, rsp_ovf},  {31'd0, ev});
        chk("rsp_err",  {31'd0, rsp_err},  {31'd0, ee});
        if (bp) begin
            cmd_valid = 1'b1; cmd_op = 5'd1; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd20;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("bp_data", rsp_data, er);
                chk("bp_flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, {29'd0, ez, ev, ee});
                chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                chk("bp_count", {16'd0, op_count}, exp_count);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        if (ew) mdl[rd] = er;
        exp_count = (exp_count + 1) % 65536;
        @(negedge clk);
        chk("op_count", {16'd0, op_count}, exp_count);
        chk("post_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rf_dest", rf[rd], mdl[rd]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner [4];
        logic [4:0]  rop;
        int          seen_rsp, w;
        corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_rsp", {rsp_data[28:0], rsp_zero, rsp_ovf, rsp_err}, 32'd0);
        for (int i = 0; i < 32; i++) preload(i[4:0], $urandom);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

        preload(5'd1, 32'd5); preload(5'd2, 32'd7);
        do_cmd(5'd1, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("add_r3", rf[3], 32'd12);

        preload(5'd5, 32'h7FFF_FFFF); preload(5'd6, 32'd1);
        do_cmd(5'd1, 5'd5, 5'd6, 5'd7, 1'b0);
        chk("add_ovf_r7", rf[7], 32'h8000_0000);
        preload(5'd8, 32'h8000_0000); preload(5'd9, 32'd1);
        do_cmd(5'd2, 5'd8, 5'd9, 5'd10, 1'b0);
        chk("sub_ovf_r10", rf[10], 32'h7FFF_FFFF);

        preload(5'd4, 32'hA5A5_A5A5);
        do_cmd(5'd5, 5'd4, 5'd4, 5'd4, 1'b0);
        chk("xor_alias_r4", rf[4], 32'd0);

        do_cmd(5'd9, 5'd1, 5'd2, 5'd11, 1'b0);
        do_cmd(5'd0, 5'd1, 5'd2, 5'd12, 1'b0);

        do_cmd(5'd3, 5'd1, 5'd2, 5'd13, 1'b1);
        do_cmd(5'd4, 5'd1, 5'd2, 5'd14, 1'b0);

        // Reset asserted while the writeback pulse is visible.
        preload(5'd1, 32'd100); preload(5'd2, 32'd23);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 5'd1; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd31;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rf_we && w < 10);
        chk("mid_rst_we_seen", {31'd0, rf_we}, 32'd1);
        rst_n = 1'b0;
        seen_rsp = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
        chk("mid_rst_count", {16'd0, op_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        exp_count = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        chk("mid_rst_no_rsp", seen_rsp, 32'd0);
        chk("post_rst_count", {16'd0, op_count}, 32'd0);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        preload(5'd31, 32'd0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0)
                preload(5'($urandom_range(0, 31)), corner[$urandom_range(0, 3)]);
            if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(7, 31));
            else rop = 5'($urandom_range(0, 6));
            do_cmd(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
